// File: rtl/alu_pkg.sv
// Shared definitions for the alu_md execute unit.
//   - 4-bit operation codes (OP_AND .. OP_DIVU)
//   - is_md(op): true for the four iterative multiply/divide codes
package alu_pkg;

  localparam logic [3:0] OP_AND    = 4'b0000;
  localparam logic [3:0] OP_OR     = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_XOR    = 4'b0011;
  localparam logic [3:0] OP_NOR    = 4'b0100;
  localparam logic [3:0] OP_SLTU   = 4'b0101;
  localparam logic [3:0] OP_SUB    = 4'b0110;
  localparam logic [3:0] OP_SLT    = 4'b0111;
  localparam logic [3:0] OP_SLL    = 4'b1000;
  localparam logic [3:0] OP_SRL    = 4'b1001;
  localparam logic [3:0] OP_SRA    = 4'b1010;
  localparam logic [3:0] OP_MTHILO = 4'b1011;
  localparam logic [3:0] OP_MULT   = 4'b1100;
  localparam logic [3:0] OP_MULTU  = 4'b1101;
  localparam logic [3:0] OP_DIV    = 4'b1110;
  localparam logic [3:0] OP_DIVU   = 4'b1111;

  function automatic logic is_md(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative multiply/divide engine.
// Works on operand magnitudes (shift-add multiply, restoring divide), one
// iteration per cycle for WIDTH cycles, then applies the sign fix-up.
// Ports:
//   clk, rst        clock, synchronous active-high reset (aborts a running op)
//   launch          accept pulse from the top (start & idle & mul/div op)
//   op, a, b        operation and operands, sampled only on launch
//   busy            operation in progress
//   done            one-cycle pulse following the hi/lo write
//   wr_en           combinational strobe: hi/lo must be written at this edge
//   wr_hi, wr_lo    final result presented with wr_en
module md_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             launch,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_hi,
  output logic [WIDTH-1:0] wr_lo
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);

  logic [SHW:0]         cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;     // negate product / quotient
  logic                 rneg_q, rneg_d;   // negate remainder
  logic                 dz_q, dz_d;       // divide by zero
  logic [WIDTH-1:0]     a_q, a_d;         // raw dividend, returned in hi on divide by zero
  logic [WIDTH-1:0]     m_q, m_d;         // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc_q, acc_d;     // mul: {partial, multiplier}; div: {remainder, quotient}

  logic             sgn_op, div_op, sa, sb, fin;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   sum, trial, diff;

  always_comb begin
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    a_d      = a_q;
    m_d      = m_q;
    acc_d    = acc_q;
    fin      = 1'b0;

    div_op = (op == OP_DIV) || (op == OP_DIVU);
    sgn_op = (op == OP_MULT) || (op == OP_DIV);
    sa     = sgn_op & a[WIDTH-1];
    sb     = sgn_op & b[WIDTH-1];
    mag_a  = sa ? (~a + 1'b1) : a;
    mag_b  = sb ? (~b + 1'b1) : b;

    // Multiply step: add multiplicand to the upper half when the multiplier LSB is set, shift right.
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? m_q : '0)};
    // Divide step: shift next dividend bit into the remainder and trial-subtract the divisor.
    trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff  = trial - {1'b0, m_q};

    if (launch && !busy_q) begin
      busy_d   = 1'b1;
      cnt_d    = CNT_INIT;
      is_div_d = div_op;
      neg_d    = sa ^ sb;
      rneg_d   = sa;
      dz_d     = div_op && (b == '0);
      a_d      = a;
      m_d      = div_op ? mag_b : mag_a;
      acc_d    = div_op ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
    end else if (busy_q) begin
      if (is_div_q) begin
        // diff[WIDTH] is the borrow: set means the divisor did not fit.
        if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else              acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == (SHW+1)'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        fin    = 1'b1;
      end
    end
  end

  // Sign fix-up of the final accumulator value, presented with the write strobe.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    prod  = neg_q ? (~acc_d + 1'b1) : acc_d;
    quo   = neg_q ? (~acc_d[WIDTH-1:0] + 1'b1) : acc_d[WIDTH-1:0];
    rem   = rneg_q ? (~acc_d[2*WIDTH-1:WIDTH] + 1'b1) : acc_d[2*WIDTH-1:WIDTH];
    wr_hi = prod[2*WIDTH-1:WIDTH];
    wr_lo = prod[WIDTH-1:0];
    if (is_div_q) begin
      wr_hi = dz_q ? a_q : rem;
      wr_lo = dz_q ? '1  : quo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      a_q      <= '0;
      m_q      <= '0;
      acc_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      a_q      <= a_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign wr_en = fin;

endmodule

// File: rtl/alu_md.sv
// MIPS execute unit: combinational ALU plus HI/LO registers fed by an
// iterative multiply/divide engine (md_unit) or by MTHILO.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   a, b, op, start  operands, op select, launch for sequential ops
//   res              combinational result (0 for ops 1011-1111)
//   zero             a == b
//   overflow         signed overflow of ADD/SUB
//   busy, done       mul/div handshake
//   hi, lo           HI/LO registers
module alu_md
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             start,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] add_r, sub_r, wr_hi, wr_lo;
  logic [SHW-1:0]   shamt;
  logic             accept, md_wr, md_busy, md_done;

  // A start is only honoured while the engine is idle (including the done cycle).
  assign accept = start && !md_busy;

  md_unit #(.WIDTH(WIDTH)) u_md (
    .clk    (clk),
    .rst    (rst),
    .launch (accept && is_md(op)),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (md_busy),
    .done   (md_done),
    .wr_en  (md_wr),
    .wr_hi  (wr_hi),
    .wr_lo  (wr_lo)
  );

  always_comb begin
    add_r = a + b;
    sub_r = a - b;
    shamt = a[SHW-1:0];
    res   = '0;
    unique case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  res = add_r;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b);
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SUB:  res = sub_r;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  res = b << shamt;
      OP_SRL:  res = b >> shamt;
      OP_SRA:  res = $unsigned($signed(b) >>> shamt);
      default: res = '0;
    endcase

    overflow = 1'b0;
    if (op == OP_ADD)
      overflow = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
    else if (op == OP_SUB)
      overflow = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
  end

  assign zero = (a == b);

  // MTHILO and a mul/div completion can never coincide: MTHILO needs busy=0,
  // completion happens while busy=1.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (accept && (op == OP_MTHILO)) begin
      hi_d = a;
      lo_d = b;
    end else if (md_wr) begin
      hi_d = wr_hi;
      lo_d = wr_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = md_busy;
  assign done = md_done;

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md (WIDTH=32): directed and random ALU ops,
// mul/div/MTHILO transactions, busy protection, reset abort, back-to-back.
module tb_alu_md;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0]   op = 4'd0;
  logic         start = 1'b0;
  logic [W-1:0] res, hi, lo;
  logic         zero, overflow, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  alu_md #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .start(start),
    .res(res), .zero(zero), .overflow(overflow), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference ALU result from plain arithmetic on the operands.
  function automatic logic [W-1:0] ref_res(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy;
    sx = int'(x);
    sy = int'(y);
    case (o)
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_ADD:  return x + y;
      OP_XOR:  return x ^ y;
      OP_NOR:  return ~(x | y);
      OP_SLTU: return (x < y) ? 32'd1 : 32'd0;
      OP_SUB:  return x - y;
      OP_SLT:  return (sx < sy) ? 32'd1 : 32'd0;
      OP_SLL:  return y << x[4:0];
      OP_SRL:  return y >> x[4:0];
      OP_SRA:  return 32'(sy >>> x[4:0]);
      default: return '0;
    endcase
  endfunction

  // Overflow: exact signed result does not fit in 32 bits.
  function automatic logic ref_ovf(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint s;
    if (o == OP_ADD)      s = longint'(int'(x)) + longint'(int'(y));
    else if (o == OP_SUB) s = longint'(int'(x)) - longint'(int'(y));
    else                  return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Expected {hi, lo} of a mul/div op.
  function automatic logic [63:0] md_model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    logic [63:0] u;
    int sx, sy, q, r;
    case (o)
      OP_MULT: begin
        p = longint'(int'(x)) * longint'(int'(y));
        return 64'(p);
      end
      OP_MULTU: begin
        u = {32'd0, x} * {32'd0, y};
        return u;
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (o == OP_DIVU) return {x % y, x / y};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sx = int'(x);
        sy = int'(y);
        q = sx / sy;
        r = sx % sy;
        return {32'(r), 32'(q)};
      end
    endcase
  endfunction

  // Called at a negedge; start is sampled at the next posedge. Operands are
  // scrambled afterwards so the running op must not depend on them.
  task automatic launch(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom; op = 4'($urandom);
  endtask

  // Entered at the first busy negedge; leaves at the negedge where done is high.
  task automatic wait_md(input string tag, input int exp_cyc, input logic [63:0] exp_hilo);
    int cyc = 0;
    int early_done = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (done === 1'b1) early_done++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({tag, " done_during_busy"}, 64'(early_done), 64'd0);
    check({tag, " done_pulse"}, 64'(done), 64'd1);
    check({tag, " hilo"}, {hi, lo}, exp_hilo);
    $display("md %s: hi=%h lo=%h busy_cycles=%0d", tag, hi, lo, cyc);
  endtask

  task automatic run_md(input string tag, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    launch(o, x, y);
    wait_md(tag, 32, md_model(o, x, y));
    @(negedge clk);
    check({tag, " done_fall"}, 64'(done), 64'd0);
  endtask

  task automatic alu_check(input string tag, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b0;
    #1;
    check({tag, " res"}, 64'(res), 64'(ref_res(o, x, y)));
    check({tag, " ovf"}, 64'(overflow), 64'(ref_ovf(o, x, y)));
    check({tag, " zero"}, 64'(zero), 64'(x == y));
    $display("alu %s: op=%0d a=%h b=%h res=%h ovf=%0d zero=%0d", tag, o, x, y, res, overflow, zero);
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] x, y, sx, sy;
    logic [3:0]   o;
    int           dcnt;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);

    // Directed compare/overflow/shift cases with absolute expectations
    op = OP_ADD; a = 32'h7FFF_FFFF; b = 32'h0000_0001; #1;
    check("add_ovf res", 64'(res), 64'h8000_0000);
    check("add_ovf ovf", 64'(overflow), 64'd1);
    op = OP_SUB; a = 32'h8000_0000; b = 32'h0000_0001; #1;
    check("sub_ovf res", 64'(res), 64'h7FFF_FFFF);
    check("sub_ovf ovf", 64'(overflow), 64'd1);
    op = OP_SLT; a = 32'hFFFF_FFFF; b = 32'h1; #1;
    check("slt", 64'(res), 64'd1);
    op = OP_SLTU; #1;
    check("sltu", 64'(res), 64'd0);
    op = OP_SRA; a = 32'd4; b = 32'h8000_0000; #1;
    check("sra", 64'(res), 64'hF800_0000);
    op = OP_SRL; #1;
    check("srl", 64'(res), 64'h0800_0000);
    @(negedge clk);

    // Random combinational ops (start low, including the 1011-1111 codes)
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 15));
      x = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
      y = (i % 5 == 0) ? x : ((i % 6 == 0) ? 32'h7FFF_FFFF : $urandom);
      alu_check($sformatf("rnd%0d", i), o, x, y);
    end

    // Directed mul/div with absolute expectations
    launch(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_md("mult_dir", 32, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    @(negedge clk);
    check("mult_dir done_fall", 64'(done), 64'd0);
    launch(OP_MULTU, 32'hFFFF_FFFD, 32'd7);
    wait_md("multu_dir", 32, {32'h0000_0006, 32'hFFFF_FFEB});
    @(negedge clk);
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_md("div_dir", 32, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    @(negedge clk);
    launch(OP_DIVU, 32'h0000_0064, 32'd0);
    wait_md("divu_dz", 32, {32'h0000_0064, 32'hFFFF_FFFF});
    @(negedge clk);
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_md("div_minneg", 32, {32'h0000_0000, 32'h8000_0000});
    @(negedge clk);
    run_md("div_dz_signed", OP_DIV, 32'hFFFF_FF00, 32'd0);

    // MTHILO while idle
    launch(OP_MTHILO, 32'h1234_5678, 32'h9ABC_DEF0);
    check("mthilo hi", 64'(hi), 64'h1234_5678);
    check("mthilo lo", 64'(lo), 64'h9ABC_DEF0);
    check("mthilo busy", 64'(busy), 64'd0);
    check("mthilo done", 64'(done), 64'd0);
    $display("mthilo: hi=%h lo=%h", hi, lo);
    @(negedge clk);

    // Random mul/div transactions
    for (int i = 0; i < 12; i++) begin
      o = 4'($urandom_range(12, 15));
      x = (i % 4 == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      y = (i % 5 == 0) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom);
      run_md($sformatf("md_rnd%0d", i), o, x, y);
    end

    // Busy protection: MTHILO then DIV requested mid-MULT must be ignored
    sx = $urandom; sy = $urandom;
    launch(OP_MULT, sx, sy);
    repeat (9) @(negedge clk);
    op = OP_MTHILO; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; start = 1'b1;
    @(negedge clk);
    op = OP_DIV; a = 32'h0000_0100; b = 32'h0000_0003; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_md("busy_protect", 21, md_model(OP_MULT, sx, sy));
    @(negedge clk);
    check("busy_protect idle", 64'(busy), 64'd0);

    // Reset abort at busy cycle 5
    launch(OP_MULT, 32'h0001_0003, 32'h0002_0005);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort hilo", {hi, lo}, 64'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dcnt++;
      @(negedge clk);
    end
    check("abort no_done", 64'(dcnt), 64'd0);
    check("abort hilo_hold", {hi, lo}, 64'd0);
    $display("abort: hi=%h lo=%h done_pulses=%0d", hi, lo, dcnt);

    // Back-to-back: second MULT started in the done cycle of the first
    sx = $urandom; sy = $urandom;
    launch(OP_MULT, 32'h0000_0011, 32'hFFFF_FFF0);
    wait_md("b2b_first", 32, md_model(OP_MULT, 32'h0000_0011, 32'hFFFF_FFF0));
    launch(OP_MULTU, sx, sy);
    wait_md("b2b_second", 32, md_model(OP_MULTU, sx, sy));
    @(negedge clk);
    check("b2b done_fall", 64'(done), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
Parametrised next-generation execute unit for the MIPS datapath. Single-cycle ops are a combinational ALU widened to a 4-bit op set: logic, add/sub, signed/unsigned compare, shifts and signed overflow. It also contains an iterative multiply/divide engine writing HI/LO, controlled by a start/busy/done handshake. The controller stalls the pipeline while busy=1.

Parameters:
WIDTH, 32, operand/result width; must be ≥ 2 and a power of two.
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
a  in  WIDTH  operand A; for shifts, the shift amount is a[SHW-1:0]
b  in  WIDTH  operand B; for shifts, the value being shifted
op  in  4  operation select
start  in  1  launch a sequential op (MULT/MULTU/DIV/DIVU/MTHILO); ignored for others
res  out  WIDTH  combinational result
zero  out  1  (a == b), independent of op
overflow  out  1  signed overflow for ADD/SUB, else 0
busy  out  1  mul/div in progress
done  out  1  one-cycle pulse: hi/lo freshly written by mul/div
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR
  - 0101 SLTU, 0110 SUB, 0111 SLT
  - 1000 SLL, 1001 SRL, 1010 SRA (b shifted by a[SHW-1:0])
  - 1011 MTHILO, 1100 MULT, 1101 MULTU, 1110 DIV, 1111 DIVU
- res for combinational ops: same-cycle, wrap-around modulo 2^WIDTH. SLT/SLTU return 1 or 0, zero-extended.
- res = 0 for op 1011–1111.
- overflow: ADD = operand signs equal and result sign differs; SUB = operand signs differ and result sign differs from a. 0 for all other ops.
- Reset: hi=0, lo=0, busy=0, done=0, counter=0.
- Reset during a mul/div aborts it; no hi/lo write.
- Accept: start=1 and busy=0 at edge k.
- MTHILO accepted: hi<=a, lo<=b at edge k. busy stays 0; no done pulse.
- MULT/MULTU/DIV/DIVU accepted:
  - Operands and op are latched; busy=1 from edge k.
  - Counter is loaded with WIDTH; one shift-add (mul) or restoring-subtract (div) iteration per cycle.
  - At edge k+WIDTH: hi/lo written, busy→0, done→1.
  - done→0 at edge k+WIDTH+1.
  - Total: busy high exactly WIDTH cycles.
- Back-to-back: start may be reasserted in the done cycle and is accepted.
- start while busy=1: ignored, including MTHILO. The running op is unaffected.
- MULT: signed 2W-bit product; hi = upper half, lo = lower half. MULTU: unsigned equivalent.
- DIV: magnitudes divided, then sign-fixed.
  - lo = quotient truncated toward zero; sign = sign(a) ^ sign(b).
  - hi = remainder; sign = sign(a).
- DIVU: unsigned; lo = quotient, hi = remainder.
- Divide by zero (b=0, DIV or DIVU): lo = all ones, hi = a. Full WIDTH latency still applies.
- DIV of most-negative by -1: lo = most-negative, hi = 0. No trap.
- hi/lo hold their value at all other times.
- Changes on a/b/op while busy do not affect the running op.

Decomposition:
- Package alu_pkg:
  - op code localparams (OP_AND … OP_DIVU)
  - helper predicate is_md(op) for the four mul/div codes
- Sub-module md_unit holds the sequential engine: counter, operand/accumulator registers, sign fix-up, busy/done.
- alu_md keeps the combinational ALU, overflow/zero logic, MTHILO write and the hi/lo registers; md_unit presents result + done.

Test Plan:
- Compare/overflow (no start):
  - ADD 7FFFFFFF + 00000001 → res=80000000, overflow=1.
  - SUB 80000000 − 00000001 → res=7FFFFFFF, overflow=1.
  - SLT a=FFFFFFFF, b=1 → 1; SLTU same operands → 0.
  - SRA b=80000000, a=4 → F8000000; SRL same → 08000000.
- MULT a=FFFFFFFD, b=7, start pulse:
  - busy high 32 cycles; done pulses once.
  - hi=FFFFFFFF, lo=FFFFFFEB.
  - MULTU same operands → hi=00000006, lo=FFFFFFEB.
- DIV a=FFFFFFF9 (−7), b=2 → lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU a=00000064, b=0 → lo=FFFFFFFF, hi=00000064 after 32 busy cycles.
- MTHILO a=12345678, b=9ABCDEF0 while idle → next cycle hi=12345678, lo=9ABCDEF0, busy=0.
- Busy-protection and abort:
  - MTHILO or DIV start at busy cycle 10 of a MULT → ignored; MULT result correct.
  - rst at busy cycle 5 → busy=0, done never pulses, hi=lo=0.
  - New MULT started in the done cycle → accepted.
